// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execution end of the 3-bit ALU control code. add/sub/and/or (and the
//   unused codes 110/111) complete in one cycle; mult (shift-add) and div
//   (restoring) iterate WIDTH cycles behind a start/busy/done handshake.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             launch an operation; sampled only in IDLE
//   ctrl              000 add, 001 sub, 010 mult, 011 div, 100 and, 101 or
//   op_a, op_b        signed operands (dividend / divisor for div)
//   busy              mult/div in flight; start is ignored
//   done              one-cycle pulse: result/result_hi/flags updated
//   result            sum/diff/logic, product low word, quotient
//   result_hi         product high word, remainder; 0 for one-cycle ops
//   zero, ovf         result == 0, signed overflow
//   div_zero          the last completed op was a divide by zero
module alu_exec_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       ctrl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             ovf,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             sa, sb;
   // mult: acc = running high word, lo = multiplier shifting out / product low word
   // div : acc = partial remainder,  lo = dividend shifting out / quotient bits in
   logic [WIDTH-1:0] acc, lo, mcand;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   assign busy = (state != S_IDLE);

   // single-cycle datapath
   logic [WIDTH-1:0] r1;
   logic             ov1;
   always_comb begin
      r1  = '0;
      ov1 = 1'b0;
      case (ctrl)
         3'b000: begin
            r1  = op_a + op_b;
            ov1 = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (r1[WIDTH-1] != op_a[WIDTH-1]);
         end
         3'b001: begin
            r1  = op_a - op_b;
            ov1 = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (r1[WIDTH-1] != op_a[WIDTH-1]);
         end
         3'b100:  r1 = op_a & op_b;
         3'b101:  r1 = op_a | op_b;
         default: r1 = '0;
      endcase
   end

   // one iteration step for each multi-cycle op
   logic [WIDTH:0] msum, dsh, dtrial;
   always_comb begin
      msum   = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
      dsh    = {acc, lo[WIDTH-1]};
      dtrial = dsh - {1'b0, mcand};
   end

   // sign fix-up once the unsigned iterations are finished
   logic                 neg;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     fq, fr;
   logic                 fovf;
   always_comb begin
      neg  = sa ^ sb;
      prod = neg ? -{acc, lo} : {acc, lo};
      fq   = neg ? -lo : lo;
      fr   = sa ? -acc : acc;
      // unsigned quotient MSB set with positive sign only for MIN / -1
      fovf = is_div ? (~neg & lo[WIDTH-1])
                    : (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         is_div    <= 1'b0;
         sa        <= 1'b0;
         sb        <= 1'b0;
         acc       <= '0;
         lo        <= '0;
         mcand     <= '0;
         done      <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               if (ctrl == 3'b010 || (ctrl == 3'b011 && op_b != '0)) begin
                  is_div <= ctrl[0];
                  sa     <= op_a[WIDTH-1];
                  sb     <= op_b[WIDTH-1];
                  lo     <= mag(op_a);
                  mcand  <= mag(op_b);
                  acc    <= '0;
                  cnt    <= CW'(WIDTH);
                  state  <= ctrl[0] ? S_DIV : S_MUL;
               end else if (ctrl == 3'b011) begin
                  done      <= 1'b1;
                  result    <= '1;
                  result_hi <= op_a;
                  zero      <= 1'b0;
                  ovf       <= 1'b0;
                  div_zero  <= 1'b1;
               end else begin
                  done      <= 1'b1;
                  result    <= r1;
                  result_hi <= '0;
                  zero      <= (r1 == '0);
                  ovf       <= ov1;
                  div_zero  <= 1'b0;
               end
            end
            S_MUL: begin
               acc <= msum[WIDTH:1];
               lo  <= {msum[0], lo[WIDTH-1:1]};
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= S_FIX;
            end
            S_DIV: begin
               if (!dtrial[WIDTH]) begin
                  acc <= dtrial[WIDTH-1:0];
                  lo  <= {lo[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= dsh[WIDTH-1:0];
                  lo  <= {lo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= S_FIX;
            end
            default: begin
               done      <= 1'b1;
               result    <= is_div ? fq : prod[WIDTH-1:0];
               result_hi <= is_div ? fr : prod[2*WIDTH-1:WIDTH];
               zero      <= is_div ? (fq == '0) : (prod[WIDTH-1:0] == '0);
               ovf       <= fovf;
               div_zero  <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  ctrl = 3'b000;
   logic [15:0] op_a = '0, op_b = '0;
   logic        busy, done, zero, ovf, div_zero;
   logic [15:0] result, result_hi;

   int cmp = 0;
   int err = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .result_hi(result_hi),
      .zero(zero), .ovf(ovf), .div_zero(div_zero)
   );

   // drive a start for one edge; returns 1 time unit after that edge (E0)
   task automatic launch(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      start = 1'b1; ctrl = c; op_a = a; op_b = b;
      @(posedge clk); #1;
      start = 1'b0; op_a = 16'h5A5A; op_b = 16'hA5A5; ctrl = 3'b111;
   endtask

   // from E0+1, run until done; n = cycle in which done is seen, bc = busy cycles
   task automatic run_to_done(output int n, output int bc);
      n = 1; bc = 0;
      while (!done && n < 40) begin
         if (busy) bc++;
         @(posedge clk); #1;
         n++;
      end
      cmp++; if (!done) begin err++; $display("FAIL done_timeout got done=%b exp 1", done); end
   endtask

   task automatic test_reset();
      #3;
      cmp++; if ({busy, done, result, result_hi, zero, ovf, div_zero} !== 37'd0) begin
         err++; $display("FAIL reset_outputs got %h exp 0", {busy, done, result, result_hi, zero, ovf, div_zero}); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_add();
      launch(3'b000, 16'h7FFF, 16'h0001);
      cmp++; if (done !== 1'b1) begin err++; $display("FAIL add_done got %b exp 1", done); end
      cmp++; if (busy !== 1'b0) begin err++; $display("FAIL add_busy got %b exp 0", busy); end
      cmp++; if (result !== 16'h8000) begin err++; $display("FAIL add_result got %h exp 8000", result); end
      cmp++; if ({ovf, zero, result_hi} !== {1'b1, 1'b0, 16'h0}) begin
         err++; $display("FAIL add_flags got ovf=%b zero=%b hi=%h exp 1 0 0000", ovf, zero, result_hi); end
      @(posedge clk); #1;
      cmp++; if (done !== 1'b0) begin err++; $display("FAIL add_done_pulse got %b exp 0", done); end
   endtask

   task automatic test_back_to_back();
      launch(3'b001, 16'd5, 16'd5);
      cmp++; if ({done, result, zero, ovf} !== {1'b1, 16'h0, 1'b1, 1'b0}) begin
         err++; $display("FAIL sub_zero got done=%b r=%h z=%b o=%b exp 1 0000 1 0", done, result, zero, ovf); end
      // new start in the done cycle
      start = 1'b1; ctrl = 3'b100; op_a = 16'hF0F0; op_b = 16'h0FF0;
      @(posedge clk); #1; start = 1'b0;
      cmp++; if ({done, result, zero} !== {1'b1, 16'h00F0, 1'b0}) begin
         err++; $display("FAIL b2b_and got done=%b r=%h z=%b exp 1 00f0 0", done, result, zero); end
      launch(3'b101, 16'hF000, 16'h000F);
      cmp++; if (result !== 16'hF00F) begin err++; $display("FAIL or_result got %h exp f00f", result); end
      launch(3'b001, 16'h8000, 16'h0001);
      cmp++; if ({result, ovf} !== {16'h7FFF, 1'b1}) begin
         err++; $display("FAIL sub_ovf got r=%h o=%b exp 7fff 1", result, ovf); end
   endtask

   task automatic test_mult();
      int n, bc;
      launch(3'b010, 16'hFFFD, 16'd7);
      run_to_done(n, bc);
      cmp++; if (bc !== 17) begin err++; $display("FAIL mul_busy_cycles got %0d exp 17", bc); end
      cmp++; if (n !== 18) begin err++; $display("FAIL mul_done_cycle got %0d exp 18", n); end
      cmp++; if (busy !== 1'b0) begin err++; $display("FAIL mul_busy_at_done got %b exp 0", busy); end
      cmp++; if ({result_hi, result, ovf} !== {32'hFFFF_FFEB, 1'b0}) begin
         err++; $display("FAIL mul_neg got %h%h o=%b exp ffffffeb 0", result_hi, result, ovf); end
      launch(3'b010, 16'd300, 16'd300);
      run_to_done(n, bc);
      cmp++; if ({result_hi, result, ovf} !== {32'h0001_5F90, 1'b1}) begin
         err++; $display("FAIL mul_big got %h%h o=%b exp 00015f90 1", result_hi, result, ovf); end
   endtask

   task automatic test_div();
      int n, bc;
      launch(3'b011, 16'hFFF9, 16'd2);
      run_to_done(n, bc);
      cmp++; if (n !== 18) begin err++; $display("FAIL div_done_cycle got %0d exp 18", n); end
      cmp++; if ({result, result_hi, ovf} !== {16'hFFFD, 16'hFFFF, 1'b0}) begin
         err++; $display("FAIL div_neg got q=%h r=%h o=%b exp fffd ffff 0", result, result_hi, ovf); end
      launch(3'b011, 16'd7, 16'hFFFE);
      run_to_done(n, bc);
      cmp++; if ({result, result_hi} !== {16'hFFFD, 16'h0001}) begin
         err++; $display("FAIL div_negdiv got q=%h r=%h exp fffd 0001", result, result_hi); end
      launch(3'b011, 16'h8000, 16'hFFFF);
      run_to_done(n, bc);
      cmp++; if ({result, result_hi, ovf, zero} !== {16'h8000, 16'h0, 1'b1, 1'b0}) begin
         err++; $display("FAIL div_min got q=%h r=%h o=%b z=%b exp 8000 0000 1 0", result, result_hi, ovf, zero); end
   endtask

   task automatic test_div_zero();
      launch(3'b011, 16'd1234, 16'd0);
      cmp++; if ({done, busy} !== 2'b10) begin err++; $display("FAIL dz_handshake got done=%b busy=%b exp 1 0", done, busy); end
      cmp++; if ({result, result_hi, div_zero, ovf} !== {16'hFFFF, 16'd1234, 1'b1, 1'b0}) begin
         err++; $display("FAIL dz_outputs got r=%h hi=%h dz=%b o=%b exp ffff 04d2 1 0", result, result_hi, div_zero, ovf); end
      @(posedge clk); #1;
      cmp++; if (div_zero !== 1'b1) begin err++; $display("FAIL dz_hold got %b exp 1", div_zero); end
      launch(3'b110, 16'h1234, 16'h4321);
      cmp++; if ({done, result, result_hi, div_zero, ovf, zero} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b1}) begin
         err++; $display("FAIL op110 got done=%b r=%h hi=%h dz=%b o=%b z=%b exp 1 0 0 0 0 1", done, result, result_hi, div_zero, ovf, zero); end
      launch(3'b000, 16'h0003, 16'h0004);
   endtask

   task automatic test_abort();
      int bad = 0;
      launch(3'b010, 16'd9, 16'd9);
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (k == 4) begin start = 1'b1; ctrl = 3'b000; op_a = 16'd1; op_b = 16'd1; end
         if (k == 5) start = 1'b0;
         if (!busy || done) bad++;
      end
      cmp++; if (bad !== 0) begin err++; $display("FAIL abort_ignore_start got %0d bad cycles exp 0", bad); end
      cmp++; if (result !== 16'h0007) begin err++; $display("FAIL abort_result_held got %h exp 0007", result); end
      rst = 1'b1; #1;
      cmp++; if ({busy, done, result, result_hi, zero, ovf, div_zero} !== 37'd0) begin
         err++; $display("FAIL abort_reset got %h exp 0", {busy, done, result, result_hi, zero, ovf, div_zero}); end
      @(negedge clk); rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done || busy) bad++;
      end
      cmp++; if (bad !== 0) begin err++; $display("FAIL abort_no_done got %0d bad cycles exp 0", bad); end
      launch(3'b000, 16'd2, 16'd3);
      cmp++; if ({done, result} !== {1'b1, 16'd5}) begin
         err++; $display("FAIL abort_then_add got done=%b r=%h exp 1 0005", done, result); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_mult();
      test_div();
      test_div_zero();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1);
   end

endmodule
